// File: rtl/msx_snd_pkg.sv
// Shared types and timing constants for the MSX sound-chip write path.
package msx_snd_pkg;

   localparam int OPLL_ADDR_WAIT = 12;
   localparam int OPLL_DATA_WAIT = 84;
   localparam int OPLL_CHIP_W    = 3;

   typedef struct packed {
      logic [OPLL_CHIP_W-1:0] chip;
      logic                   a0;
      logic [7:0]             data;
   } opll_wr_t;

   typedef enum logic [1:0] {IDLE, STROBE, RELEASE} wrq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push when full and pop when empty are ignored.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign count   = wr_ptr - rd_ptr;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/dev_opll_wrq.sv
// Write queue, per-chip timing scheduler and saturating output mixer for N OPLL-class FM chips.
module dev_opll_wrq
   import msx_snd_pkg::*;
#(
   parameter  int NUM_CHIPS = 3,
   parameter  int DEPTH     = 16,
   parameter  int ADDR_WAIT = OPLL_ADDR_WAIT,
   parameter  int DATA_WAIT = OPLL_DATA_WAIT,
   parameter  int OUT_SHIFT = 0,
   localparam int IW        = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    ce_3m58,
   input  logic                    wr_req,
   input  logic [IW-1:0]           wr_chip,
   input  logic                    wr_a0,
   input  logic [7:0]              wr_data,
   output logic                    wr_ready,
   output logic [7:0]              drop_cnt,
   output logic [NUM_CHIPS-1:0]    chip_cs_n,
   output logic                    chip_wr_n,
   output logic                    chip_a0,
   output logic [7:0]              chip_d,
   input  logic [NUM_CHIPS*16-1:0] chip_snd,
   input  logic [NUM_CHIPS-1:0]    chip_en,
   output logic signed [15:0]      sound,
   output logic                    clip
);

   localparam int CW = $clog2(DATA_WAIT + 1);
   localparam int AW = 16 + $clog2(NUM_CHIPS) + 1;
   localparam int QW = $bits(opll_wr_t);
   localparam int NW = $clog2(DEPTH) + 1;
   localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
   localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

   opll_wr_t                 wr_ent;
   opll_wr_t                 head;
   logic [QW-1:0]            head_raw;
   logic                     full;
   logic                     empty;
   logic [NW-1:0]            fifo_cnt;
   logic                     push;
   logic                     pop;
   logic                     chip_ok;
   logic                     head_blocked;
   logic [CW-1:0]            cnt [NUM_CHIPS];
   wrq_state_t               state;
   wrq_state_t               state_nx;
   logic [OPLL_CHIP_W-1:0]   cur_chip;
   logic [OPLL_CHIP_W-1:0]   cur_chip_nx;
   logic                     ce_seen;
   logic                     ce_seen_nx;
   logic [NUM_CHIPS-1:0]     cs_n_nx;
   logic                     wr_n_nx;
   logic                     a0_nx;
   logic [7:0]               d_nx;
   logic signed [AW-1:0]     acc;
   logic signed [AW-1:0]     acc_sh;
   logic signed [15:0]       lane;

   function automatic logic [16:0] sat16(input logic signed [AW-1:0] v);
      if (v > SAT_MAX)      return {1'b1, 16'h7FFF};
      else if (v < SAT_MIN) return {1'b1, 16'h8000};
      else                  return {1'b0, v[15:0]};
   endfunction

   assign chip_ok  = 32'(wr_chip) < NUM_CHIPS;
   assign push     = wr_req && !full && chip_ok;
   assign wr_ent   = '{chip: OPLL_CHIP_W'(wr_chip), a0: wr_a0, data: wr_data};
   assign head     = opll_wr_t'(head_raw);
   assign wr_ready = (fifo_cnt != NW'(DEPTH));

   sync_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (wr_ent),
      .dout    (head_raw),
      .full    (full),
      .empty   (empty),
      .count   (fifo_cnt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                 drop_cnt <= '0;
      else if (wr_req && !push && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
   end

   // The head's own counter gates issue; a blocked head stalls the whole queue to keep CPU order.
   always_comb begin
      head_blocked = 1'b0;
      for (int k = 0; k < NUM_CHIPS; k++)
         if (head.chip == OPLL_CHIP_W'(k) && cnt[k] != '0) head_blocked = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_CHIPS; k++) cnt[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CHIPS; k++) begin
            if (state == RELEASE && cur_chip == OPLL_CHIP_W'(k))
               cnt[k] <= chip_a0 ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
            else if (ce_3m58 && cnt[k] != '0)
               cnt[k] <= cnt[k] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cur_chip  <= '0;
         ce_seen   <= 1'b0;
         chip_cs_n <= '1;
         chip_wr_n <= 1'b1;
         chip_a0   <= 1'b0;
         chip_d    <= '0;
      end else begin
         state     <= state_nx;
         cur_chip  <= cur_chip_nx;
         ce_seen   <= ce_seen_nx;
         chip_cs_n <= cs_n_nx;
         chip_wr_n <= wr_n_nx;
         chip_a0   <= a0_nx;
         chip_d    <= d_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cur_chip_nx = cur_chip;
      ce_seen_nx  = ce_seen;
      cs_n_nx     = chip_cs_n;
      wr_n_nx     = chip_wr_n;
      a0_nx       = chip_a0;
      d_nx        = chip_d;
      pop         = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && !head_blocked) begin
               pop         = 1'b1;
               cur_chip_nx = head.chip;
               a0_nx       = head.a0;
               d_nx        = head.data;
               cs_n_nx     = ~(NUM_CHIPS'(1) << head.chip);
               wr_n_nx     = 1'b0;
               ce_seen_nx  = 1'b0;
               state_nx    = STROBE;
            end
         end
         // Release on the second master pulse so the strobe covers a full master period.
         STROBE: begin
            if (ce_3m58) begin
               if (ce_seen) begin
                  cs_n_nx  = '1;
                  wr_n_nx  = 1'b1;
                  state_nx = RELEASE;
               end else begin
                  ce_seen_nx = 1'b1;
               end
            end
         end
         RELEASE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      acc  = '0;
      lane = '0;
      for (int k = 0; k < NUM_CHIPS; k++) begin
         lane = chip_snd[16*k +: 16];
         if (chip_en[k]) acc = acc + {{(AW-16){lane[15]}}, lane};
      end
      acc_sh = acc >>> OUT_SHIFT;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) {clip, sound} <= '0;
      else          {clip, sound} <= sat16(acc_sh);
   end

endmodule

// File: tb/tb_dev_opll_wrq.sv
// Directed bench for dev_opll_wrq: queueing, strobe timing, drops, mixer and async reset.
module tb_dev_opll_wrq;

   localparam int NC = 3;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              ce_3m58 = 1'b0;
   logic              wr_req = 1'b0;
   logic [1:0]        wr_chip = '0;
   logic              wr_a0 = 1'b0;
   logic [7:0]        wr_data = '0;
   logic              wr_ready;
   logic [7:0]        drop_cnt;
   logic [NC-1:0]     chip_cs_n;
   logic              chip_wr_n;
   logic              chip_a0;
   logic [7:0]        chip_d;
   logic [NC*16-1:0]  chip_snd = '0;
   logic [NC-1:0]     chip_en = '0;
   logic signed [15:0] sound;
   logic              clip;

   int n_chk = 0;
   int n_err = 0;
   int clk_cnt = 0;
   int ce_total = 0;
   int ce_div = 0;
   logic prev_wr_n = 1'b1;
   logic [11:0] s_ent[$];
   int s_ce[$];
   int s_clk[$];
   int r_clk[$];

   dev_opll_wrq #(.NUM_CHIPS(NC), .DEPTH(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce_3m58   (ce_3m58),
      .wr_req    (wr_req),
      .wr_chip   (wr_chip),
      .wr_a0     (wr_a0),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .drop_cnt  (drop_cnt),
      .chip_cs_n (chip_cs_n),
      .chip_wr_n (chip_wr_n),
      .chip_a0   (chip_a0),
      .chip_d    (chip_d),
      .chip_snd  (chip_snd),
      .chip_en   (chip_en),
      .sound     (sound),
      .clip      (clip)
   );

   always #5 clk = ~clk;

   // Master-clock enable: one clk wide, every fourth clk.
   initial forever begin
      @(posedge clk);
      #1;
      ce_div  = (ce_div + 1) % 4;
      ce_3m58 = (ce_div == 0);
   end

   always @(posedge clk) begin
      clk_cnt <= clk_cnt + 1;
      if (ce_3m58) ce_total <= ce_total + 1;
   end

   always @(negedge clk) begin
      if (prev_wr_n && !chip_wr_n) begin
         s_ent.push_back({chip_cs_n, chip_a0, chip_d});
         s_ce.push_back(ce_total);
         s_clk.push_back(clk_cnt);
      end
      if (!prev_wr_n && chip_wr_n) r_clk.push_back(clk_cnt);
      prev_wr_n <= chip_wr_n;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int c, input int a, input int d, input logic req);
      @(negedge clk);
      wr_req  = req;
      wr_chip = 2'(c);
      wr_a0   = a[0];
      wr_data = 8'(d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      wr_req  = 1'b0;
      repeat (3) @(negedge clk);
      s_ent.delete();
      s_ce.delete();
      s_clk.delete();
      r_clk.delete();
      reset_n = 1'b1;
   endtask

   task automatic wait_strobes(input string tag, input int n, input int budget);
      int t = 0;
      while (s_ent.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk(tag, 32'(s_ent.size()), 32'(n));
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_cs_n", 32'(chip_cs_n), 32'b111);
      chk("rst_wr_n", 32'(chip_wr_n), 32'd1);
      chk("rst_a0_d", {23'd0, chip_a0, chip_d}, 32'd0);
      chk("rst_sound", {15'd0, clip, sound}, 32'd0);
      reset_n = 1'b1;

      // 1: address then data write to chip 0, spacing 2+12 ce
      drive(0, 0, 8'h10, 1'b1);
      drive(0, 1, 8'h55, 1'b1);
      drive(0, 0, 0, 1'b0);
      wait_strobes("t1_count", 2, 1000);
      chk("t1_first", 32'(s_ent[0]), {20'd0, 3'b110, 1'b0, 8'h10});
      chk("t1_second", 32'(s_ent[1]), {20'd0, 3'b110, 1'b1, 8'h55});
      chk("t1_ce_gap", 32'(s_ce[1] - s_ce[0]), 32'd14);
      repeat (20) @(negedge clk);
      chk("t1_released", {28'd0, chip_cs_n, chip_wr_n}, 32'b1111);
      chk("t1_hold", {23'd0, chip_a0, chip_d}, {23'd0, 1'b1, 8'h55});

      // 2: fill queue behind a blocked head, two overflow writes, ordered replay
      do_reset();
      drive(0, 1, 8'hA0, 1'b1);
      drive(0, 0, 0, 1'b0);
      for (int t = 0; t < 100 && chip_wr_n; t++) @(negedge clk);
      chk("t2_first_strobe", 32'(chip_wr_n), 32'd0);
      for (int i = 0; i < 16; i++) drive(0, i & 1, 8'h40 + i, 1'b1);
      drive(0, 0, 8'hEE, 1'b1);
      chk("t2_full", 32'(wr_ready), 32'd0);
      drive(0, 0, 8'hEF, 1'b1);
      drive(0, 0, 0, 1'b0);
      chk("t2_drop", 32'(drop_cnt), 32'd2);
      wait_strobes("t2_count", 17, 8000);
      for (int i = 0; i < 16; i++)
         chk($sformatf("t2_order%0d", i), 32'(s_ent[i+1]),
             {20'd0, 3'b110, 1'(i & 1), 8'(8'h40 + i)});
      repeat (10) @(negedge clk);
      chk("t2_ready_after", 32'(wr_ready), 32'd1);

      // 3: other chip is not held by chip 0's data wait; chip 0 follow-up waits its own count
      do_reset();
      drive(0, 1, 8'h33, 1'b1);
      drive(1, 0, 8'h07, 1'b1);
      drive(0, 0, 8'h08, 1'b1);
      drive(0, 0, 0, 1'b0);
      wait_strobes("t3_count", 3, 2000);
      chk("t3_chip1", 32'(s_ent[1]), {20'd0, 3'b101, 1'b0, 8'h07});
      chk("t3_chip1_gap", 32'(s_clk[1] - r_clk[0]), 32'd2);
      chk("t3_chip0_again", 32'(s_ent[2]), {20'd0, 3'b110, 1'b0, 8'h08});
      chk("t3_chip0_ce_gap", 32'(s_ce[2] - s_ce[0]), 32'd86);

      // 4: out-of-range chip index is dropped, valid write afterwards still issues
      do_reset();
      drive(3, 0, 8'h11, 1'b1);
      drive(0, 0, 0, 1'b0);
      repeat (50) @(negedge clk);
      chk("t4_drop", 32'(drop_cnt), 32'd1);
      chk("t4_no_strobe", 32'(s_ent.size()), 32'd0);
      chk("t4_ready", 32'(wr_ready), 32'd1);
      drive(2, 1, 8'h22, 1'b1);
      drive(0, 0, 0, 1'b0);
      wait_strobes("t4_valid_count", 1, 200);
      chk("t4_valid", 32'(s_ent[0]), {20'd0, 3'b011, 1'b1, 8'h22});

      // 5: mixer
      @(negedge clk);
      chip_snd = {16'hFC18, 16'h7530, 16'h7530};
      chip_en  = 3'b111;
      @(negedge clk);
      chk("t5_pos_sat", {15'd0, clip, sound}, {15'd0, 1'b1, 16'h7FFF});
      chip_en = 3'b100;
      @(negedge clk);
      chk("t5_single", {15'd0, clip, sound}, {15'd0, 1'b0, 16'hFC18});
      chip_snd = {16'hFC18, 16'h8AD0, 16'h8AD0};
      chip_en  = 3'b111;
      @(negedge clk);
      chk("t5_neg_sat", {15'd0, clip, sound}, {15'd0, 1'b1, 16'h8000});
      chip_snd = {16'hFC18, 16'h4E20, 16'h2710};
      @(negedge clk);
      chk("t5_sum", {15'd0, clip, sound}, {15'd0, 1'b0, 16'h7148});
      chip_en = 3'b000;
      @(negedge clk);
      chk("t5_all_off", {15'd0, clip, sound}, 32'd0);

      // 6: async reset in the middle of a strobe with queued writes
      do_reset();
      for (int i = 0; i < 6; i++) drive(0, 0, 8'h60 + i, 1'b1);
      drive(0, 0, 0, 1'b0);
      for (int t = 0; t < 100 && chip_wr_n; t++) @(negedge clk);
      chk("t6_in_strobe", 32'(chip_wr_n), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_async_wr_n", 32'(chip_wr_n), 32'd1);
      chk("t6_async_cs_n", 32'(chip_cs_n), 32'b111);
      repeat (3) @(negedge clk);
      s_ent.delete();
      s_ce.delete();
      s_clk.delete();
      r_clk.delete();
      reset_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("t6_no_strobe", 32'(s_ent.size()), 32'd0);
      chk("t6_ready", 32'(wr_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
